// File: rtl/mux2x32_pkg.sv
// Shared constants for the 2:1 word multiplexer: default data width and
// the select encoding used by the combinational selector and the register stage.
package mux2x32_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

endpackage : mux2x32_pkg

// File: rtl/mux2_comb.sv
// Pure combinational 2:1 word selector; no clock, no reset, zero latency.
module mux2_comb
  import mux2x32_pkg::*;
#(
  parameter int unsigned WIDTH = DATA_W
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y
);

  // The conditional operator is kept on purpose: with an unknown select,
  // bits on which a and b agree still resolve instead of going all-X.
  assign y = (sel == SEL_B) ? b : a;

endmodule : mux2_comb

// File: rtl/mux2x32.sv
// 2:1 word multiplexer with a zero-latency output y and a registered copy
// y_q / sel_q for timing-critical consumers.
module mux2x32
  import mux2x32_pkg::*;
#(
  parameter int unsigned       WIDTH   = DATA_W,
  parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             sel_q
);

  mux2_comb #(
    .WIDTH (WIDTH)
  ) u_mux2_comb (
    .a   (a),
    .b   (b),
    .sel (sel),
    .y   (y)
  );

  // Free-running capture: no enable, no handshake; reset wins asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_q   <= RST_VAL;
      sel_q <= SEL_A;
    end else begin
      y_q   <= y;
      sel_q <= sel;
    end
  end

endmodule : mux2x32

// File: tb/tb_mux2x32.sv
// Bench for mux2x32: vector table for the combinational path, hand-written
// reset sequences, and a randomized phase checked against a reference model.
module tb_mux2x32;

  localparam int W = 32;

  logic         clk;
  logic         run_clk;
  logic         rst_n;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sel;
  logic [W-1:0] y;
  logic [W-1:0] y_q;
  logic         sel_q;

  int n_checks;
  int n_fail;

  logic [W-1:0] exp_q[$];
  logic         exp_sel_q[$];

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sel;
    logic [W-1:0] exp_y;
  } vec_t;

  vec_t vecs[5];

  mux2x32 #(
    .WIDTH   (W),
    .RST_VAL ('0)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .a     (a),
    .b     (b),
    .sel   (sel),
    .y     (y),
    .y_q   (y_q),
    .sel_q (sel_q)
  );

  // clock / reset block: clock only toggles once run_clk is set
  initial clk = 1'b0;
  always begin
    #5;
    if (run_clk) clk = ~clk;
  end

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: the selected word is simply the input indexed by sel
  function automatic logic [W-1:0] model_sel(input logic [W-1:0] wa, input logic [W-1:0] wb,
                                             input logic s);
    logic [W-1:0] words[2];
    words[0] = wa;
    words[1] = wb;
    return words[int'(s)];
  endfunction

  task automatic drive(input logic [W-1:0] na, input logic [W-1:0] nb, input logic ns);
    a   = na;
    b   = nb;
    sel = ns;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    run_clk  = 1'b0;
    rst_n    = 1'b1;
    drive('0, '0, 1'b0);

    vecs[0] = '{"comb_sel0",      32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5};
    vecs[1] = '{"comb_sel1",      32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A};
    vecs[2] = '{"comb_sel_back",  32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0, 32'hA5A5A5A5};
    vecs[3] = '{"comb_unsel_a",   32'hFFFFFFFF, 32'h5A5A5A5A, 1'b1, 32'h5A5A5A5A};
    vecs[4] = '{"comb_a_sel0",    32'hFFFFFFFF, 32'h5A5A5A5A, 1'b0, 32'hFFFFFFFF};

    // reset state with no clock running
    #1 rst_n = 1'b0;
    #1;
    check("rst_y_q", y_q, '0);
    check("rst_sel_q", {{(W-1){1'b0}}, sel_q}, '0);
    #1 rst_n = 1'b1;

    // combinational path, clock stopped
    for (int i = 0; i < 5; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].sel);
      #1;
      check(vecs[i].name, y, vecs[i].exp_y);
    end
    check("no_clk_y_q_hold", y_q, '0);

    // unknown select: agreeing bits pass through
    drive(32'h12345678, 32'h12345678, 1'bx);
    #1;
    check("selx_equal", y, 32'h12345678);
    drive(32'h0, 32'h1, 1'bx);
    #1;
    check("selx_upper", {1'b0, y[W-1:1]}, '0);

    // reset held with clock running, then release
    rst_n = 1'b0;
    drive(32'hA5A5A5A5, 32'h5A5A5A5A, 1'b0);
    run_clk = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_hold_y_q", y_q, '0);
    check("rst_hold_sel_q", {{(W-1){1'b0}}, sel_q}, '0);
    check("rst_hold_y", y, 32'hA5A5A5A5);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("first_capture_y_q", y_q, 32'hA5A5A5A5);
    check("first_capture_sel_q", {{(W-1){1'b0}}, sel_q}, '0);
    sel = 1'b1;
    @(posedge clk);
    #1;
    check("capture_b_y_q", y_q, 32'h5A5A5A5A);
    check("capture_b_sel_q", {{(W-1){1'b0}}, sel_q}, 32'h1);

    // mid-operation reset between edges
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_y_q", y_q, '0);
    check("mid_rst_sel_q", {{(W-1){1'b0}}, sel_q}, '0);
    check("mid_rst_y", y, 32'h5A5A5A5A);
    @(negedge clk);
    rst_n = 1'b1;

    // randomized phase: drive on negedge, check y at once and y_q after the edge
    for (int i = 0; i < 300; i++) begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rs;
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(0, 1));
      rst_n = 1'b1;
      drive(ra, rb, rs);
      if ($urandom_range(0, 15) == 0) begin
        rst_n = 1'b0;
        exp_q.push_back('0);
        exp_sel_q.push_back(1'b0);
        #1;
        check("rnd_async_rst_y_q", y_q, '0);
      end else begin
        exp_q.push_back(model_sel(ra, rb, rs));
        exp_sel_q.push_back(rs);
        #1;
      end
      check("rnd_y", y, model_sel(ra, rb, rs));
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        check("rnd_queue_empty", 32'h1, 32'h0);
      end else begin
        check("rnd_y_q", y_q, exp_q.pop_front());
        check("rnd_sel_q", {{(W-1){1'b0}}, sel_q}, {{(W-1){1'b0}}, exp_sel_q.pop_front()});
      end
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_mux2x32
